// File: rtl/counter_pkg.sv
// counter_pkg: opcode encodings and controller state enumeration shared by
// the counter sequencing controller and its bench-facing sub-blocks.
package counter_pkg;

  typedef enum logic [2:0] {
    OP_SET_LIMIT    = 3'b000,
    OP_SET_PRESCALE = 3'b001,
    OP_START_UP     = 3'b010,
    OP_START_DOWN   = 3'b011,
    OP_PAUSE        = 3'b100,
    OP_RESUME       = 3'b101,
    OP_ABORT        = 3'b110,
    OP_RSVD         = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  function automatic logic is_start(input op_e op);
    return (op == OP_START_UP) || (op == OP_START_DOWN);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: free-running divider for the count tick.
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : force the phase counter to 0 (wins over hold_i)
//   hold_i        : freeze the phase counter
//   prescale_i    : terminal phase value; tick period is prescale_i+1 cycles
//   tick_o        : high while the phase counter equals prescale_i
module counter_prescaler #(
  parameter int unsigned PS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            hold_i,
  input  logic [PS_W-1:0] prescale_i,
  output logic            tick_o
);

  logic [PS_W-1:0] count_q, count_d;

  assign tick_o = (count_q == prescale_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = tick_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for an external up/down counter.
//   clk, rst           : clock, asynchronous active-high reset
//   cmd_valid/ready    : command handshake (ready low only in LOAD)
//   cmd_op, cmd_data   : opcode and operand (limit, prescale, start value)
//   cnt_q              : current value of the external counter
//   cnt_load/_val      : one-cycle load strobe and value to the counter
//   cnt_en, cnt_up     : count-step strobe and direction
//   busy               : high in LOAD, RUN, PAUSED
//   done, err          : one-cycle pulses for terminal count / illegal command
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PS_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] load_val_q;
  logic [PS_W-1:0]  prescale_q;
  logic             up_q;
  logic             done_q;
  logic             err_q;

  op_e  op;
  logic accept;
  logic tick;
  logic at_limit;
  logic ps_clear;
  logic ps_hold;
  logic run_tick;

  assign op       = op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign at_limit = (cnt_q == limit_q);

  // Phase only advances in RUN cycles without an accepted command, so a
  // command landing on a tick defers that tick instead of dropping it, and
  // PAUSE/RESUME return to exactly the phase that was left.
  assign ps_clear = (state_q != ST_RUN) && (state_q != ST_PAUSED);
  assign ps_hold  = (state_q == ST_PAUSED) || accept;

  counter_prescaler #(
    .PS_W(PS_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (ps_clear),
    .hold_i    (ps_hold),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  assign run_tick = (state_q == ST_RUN) && tick && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      limit_q    <= '1;
      load_val_q <= '0;
      prescale_q <= '0;
      up_q       <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_start(op)) begin
              up_q       <= (op == OP_START_UP);
              load_val_q <= cmd_data;
              state_q    <= ST_LOAD;
            end else begin
              case (op)
                OP_SET_LIMIT: begin
                  limit_q <= cmd_data;
                  state_q <= ST_IDLE;
                end
                OP_SET_PRESCALE: begin
                  prescale_q <= cmd_data[PS_W-1:0];
                  state_q    <= ST_IDLE;
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
        end
        ST_LOAD: state_q <= ST_RUN;
        ST_RUN: begin
          if (accept) begin
            case (op)
              OP_PAUSE: state_q <= ST_PAUSED;
              OP_ABORT: state_q <= ST_IDLE;
              default:  err_q   <= 1'b1;
            endcase
          end else if (run_tick && at_limit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (accept) begin
            case (op)
              OP_RESUME: state_q <= ST_RUN;
              OP_ABORT:  state_q <= ST_IDLE;
              default:   err_q   <= 1'b1;
            endcase
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q != ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign cnt_load     = (state_q == ST_LOAD);
  assign cnt_load_val = cnt_load ? load_val_q : '0;
  assign cnt_en       = run_tick && !at_limit;
  assign cnt_up       = up_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PS_W  = 4;

  localparam logic [2:0] C_SET_LIMIT = 3'b000;
  localparam logic [2:0] C_SET_PS    = 3'b001;
  localparam logic [2:0] C_START_UP  = 3'b010;
  localparam logic [2:0] C_START_DN  = 3'b011;
  localparam logic [2:0] C_PAUSE     = 3'b100;
  localparam logic [2:0] C_RESUME    = 3'b101;
  localparam logic [2:0] C_ABORT     = 3'b110;
  localparam logic [2:0] C_RSVD      = 3'b111;

  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSED, M_DONE} mmode_e;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_up;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int   en_cnt, done_cnt, err_cnt;
  int   load_cyc, done_cyc, first_en_cyc, last_en_cyc, acc_cyc;
  logic last_en_up;

  counter_seq_ctrl #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cnt_q       (cnt_q),
    .cnt_load    (cnt_load),
    .cnt_load_val(cnt_load_val),
    .cnt_en      (cnt_en),
    .cnt_up      (cnt_up),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The external counter being sequenced.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  task automatic clr();
    en_cnt = 0; done_cnt = 0; err_cnt = 0;
    load_cyc = -1; done_cyc = -1; first_en_cyc = -1; last_en_cyc = -1;
    last_en_up = 1'bx;
  endtask

  // Called at the falling edge; records events of the current cycle.
  task automatic sample();
    if (cnt_load) load_cyc = cyc;
    if (cnt_en) begin
      if (en_cnt == 0) first_en_cyc = cyc;
      en_cnt++;
      last_en_cyc = cyc;
      last_en_up = cnt_up;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic watch(input int max_cyc, input bit stop_done, input bit stop_en);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk); #1;
      if ((stop_done && done_cnt > 0) || (stop_en && en_cnt > 0)) break;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample();
      acc_cyc = cyc;
      if (cmd_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cnt_load !== 1'b0) begin errors++; $display("FAIL rst_cnt_load: got %b expected 0", cnt_load); end
    checks++; if (cnt_load_val !== 8'd0) begin errors++; $display("FAIL rst_cnt_load_val: got %0d expected 0", cnt_load_val); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL rst_cnt_en: got %b expected 0", cnt_en); end
    checks++; if (cnt_up !== 1'b1) begin errors++; $display("FAIL rst_cnt_up: got %b expected 1", cnt_up); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%b err=%b expected 0,0", done, err); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_up();
    send(C_SET_LIMIT, 8'd5);
    send(C_SET_PS, 8'd0);
    clr();
    send(C_START_UP, 8'd0);
    checks++; if (cnt_load !== 1'b1 || cnt_load_val !== 8'd0) begin errors++; $display("FAIL up_load: got load=%b val=%0d expected 1,0", cnt_load, cnt_load_val); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL up_load_flags: got ready=%b busy=%b expected 0,1", cmd_ready, busy); end
    checks++; if (cnt_up !== 1'b1) begin errors++; $display("FAIL up_dir: got %b expected 1", cnt_up); end
    watch(40, 1'b1, 1'b0);
    checks++; if (en_cnt !== 5) begin errors++; $display("FAIL up_en_count: got %0d expected 5", en_cnt); end
    checks++; if (last_en_cyc - first_en_cyc !== 4) begin errors++; $display("FAIL up_en_consecutive: got span %0d expected 4", last_en_cyc - first_en_cyc); end
    checks++; if (done_cnt !== 1 || done_cyc - load_cyc !== 7) begin errors++; $display("FAIL up_done: got count=%0d latency=%0d expected 1,7", done_cnt, done_cyc - load_cyc); end
    checks++; if (cnt_q !== 8'd5) begin errors++; $display("FAIL up_final_count: got %0d expected 5", cnt_q); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL up_done_hold: got busy=%b ready=%b done=%b expected 0,1,0", busy, cmd_ready, done); end
  endtask

  task automatic test_prescale_down();
    send(C_SET_LIMIT, 8'd8);
    send(C_SET_PS, 8'd3);
    clr();
    send(C_START_DN, 8'd10);
    watch(80, 1'b1, 1'b0);
    checks++; if (en_cnt !== 2) begin errors++; $display("FAIL dn_en_count: got %0d expected 2", en_cnt); end
    checks++; if (first_en_cyc - load_cyc !== 4 || last_en_cyc - first_en_cyc !== 4) begin errors++; $display("FAIL dn_en_spacing: got first=%0d gap=%0d expected 4,4", first_en_cyc - load_cyc, last_en_cyc - first_en_cyc); end
    checks++; if (last_en_up !== 1'b0) begin errors++; $display("FAIL dn_dir: got %b expected 0", last_en_up); end
    checks++; if (done_cnt !== 1 || done_cyc - load_cyc !== 13) begin errors++; $display("FAIL dn_done: got count=%0d latency=%0d expected 1,13", done_cnt, done_cyc - load_cyc); end
    checks++; if (cnt_q !== 8'd8) begin errors++; $display("FAIL dn_final_count: got %0d expected 8", cnt_q); end
  endtask

  task automatic test_wrap();
    send(C_SET_PS, 8'd0);
    send(C_SET_LIMIT, 8'd1);
    clr();
    send(C_START_UP, 8'd254);
    watch(40, 1'b1, 1'b0);
    checks++; if (en_cnt !== 3) begin errors++; $display("FAIL wrap_en_count: got %0d expected 3", en_cnt); end
    checks++; if (done_cnt !== 1 || done_cyc - load_cyc !== 5) begin errors++; $display("FAIL wrap_done: got count=%0d latency=%0d expected 1,5", done_cnt, done_cyc - load_cyc); end
    checks++; if (cnt_q !== 8'd1) begin errors++; $display("FAIL wrap_final_count: got %0d expected 1", cnt_q); end
  endtask

  task automatic test_equal_start();
    send(C_SET_LIMIT, 8'd7);
    clr();
    send(C_START_UP, 8'd7);
    watch(20, 1'b1, 1'b0);
    checks++; if (en_cnt !== 0) begin errors++; $display("FAIL eq_en_count: got %0d expected 0", en_cnt); end
    checks++; if (done_cnt !== 1 || done_cyc - load_cyc !== 2) begin errors++; $display("FAIL eq_done: got count=%0d latency=%0d expected 1,2", done_cnt, done_cyc - load_cyc); end
  endtask

  task automatic test_pause_abort();
    send(C_SET_PS, 8'd3);
    send(C_SET_LIMIT, 8'd200);
    clr();
    send(C_START_UP, 8'd0);
    watch(20, 1'b0, 1'b1);
    checks++; if (en_cnt !== 1 || first_en_cyc - load_cyc !== 4) begin errors++; $display("FAIL pause_first_tick: got count=%0d offset=%0d expected 1,4", en_cnt, first_en_cyc - load_cyc); end
    clr();
    send(C_PAUSE, 8'd0);
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL pause_flags: got busy=%b ready=%b expected 1,1", busy, cmd_ready); end
    watch(10, 1'b0, 1'b0);
    checks++; if (en_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL pause_quiet: got en=%0d err=%0d expected 0,0", en_cnt, err_cnt); end
    clr();
    send(C_RESUME, 8'd0);
    watch(20, 1'b0, 1'b1);
    checks++; if (first_en_cyc - acc_cyc !== 4) begin errors++; $display("FAIL resume_phase: got %0d expected 4", first_en_cyc - acc_cyc); end
    clr();
    send(C_ABORT, 8'd0);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got busy=%b ready=%b expected 0,1", busy, cmd_ready); end
    watch(20, 1'b0, 1'b0);
    checks++; if (done_cnt !== 0 || en_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL abort_quiet: got done=%0d en=%0d err=%0d expected 0,0,0", done_cnt, en_cnt, err_cnt); end
  endtask

  task automatic test_err_rst();
    send(C_SET_PS, 8'd0);
    send(C_SET_LIMIT, 8'd20);
    send(C_START_UP, 8'd0);
    watch(10, 1'b0, 1'b1);
    clr();
    send(C_SET_LIMIT, 8'd3);
    send(C_RSVD, 8'd0);
    watch(60, 1'b1, 1'b0);
    checks++; if (err_cnt !== 2) begin errors++; $display("FAIL err_pulses: got %0d expected 2", err_cnt); end
    checks++; if (done_cnt !== 1 || cnt_q !== 8'd20) begin errors++; $display("FAIL err_limit_kept: got done=%0d cnt=%0d expected 1,20", done_cnt, cnt_q); end
    send(C_ABORT, 8'd0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_abort_in_done: got %b expected 1", err); end
    send(C_SET_LIMIT, 8'd50);
    send(C_START_DN, 8'd100);
    watch(10, 1'b0, 1'b1);
    clr();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || cnt_en !== 1'b0 || cnt_load !== 1'b0) begin errors++; $display("FAIL arst_outputs: got busy=%b en=%b load=%b expected 0,0,0", busy, cnt_en, cnt_load); end
    checks++; if (cnt_up !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_dir_ready: got up=%b ready=%b expected 1,1", cnt_up, cmd_ready); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || cnt_load_val !== 8'd0) begin errors++; $display("FAIL arst_misc: got done=%b err=%b val=%0d expected 0,0,0", done, err, cnt_load_val); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    watch(20, 1'b0, 1'b0);
    checks++; if (done_cnt !== 0 || en_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL arst_after: got done=%0d en=%0d busy=%b expected 0,0,0", done_cnt, en_cnt, busy); end
  endtask

  task automatic test_random();
    mmode_e           m;
    logic [WIDTH-1:0] m_lim, m_start, m_cnt, k, e_lval;
    int               m_ps, m_phase, r;
    bit               m_up, m_done_p, m_err_p;
    bit               e_ready, e_busy, e_load, acc, tick, e_en;

    rst = 1'b1; #2 rst = 1'b0;
    m = M_IDLE; m_lim = '1; m_start = '0; m_cnt = '0; m_ps = 0; m_phase = 0;
    m_up = 1'b1; m_done_p = 1'b0; m_err_p = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 99);
      k = WIDTH'($urandom_range(0, 6));
      if (r < 15)      begin cmd_op = C_SET_LIMIT; cmd_data = WIDTH'($urandom_range(0, 255)); end
      else if (r < 25) begin cmd_op = C_SET_PS;    cmd_data = WIDTH'($urandom_range(0, 3)); end
      else if (r < 40) begin cmd_op = C_START_UP;  cmd_data = m_lim - k; end
      else if (r < 55) begin cmd_op = C_START_DN;  cmd_data = m_lim + k; end
      else if (r < 67) begin cmd_op = C_PAUSE;     cmd_data = '0; end
      else if (r < 79) begin cmd_op = C_RESUME;    cmd_data = '0; end
      else if (r < 88) begin cmd_op = C_ABORT;     cmd_data = '0; end
      else             begin cmd_op = C_RSVD;      cmd_data = '0; end

      @(negedge clk);
      e_ready = (m != M_LOAD);
      e_busy  = (m == M_LOAD) || (m == M_RUN) || (m == M_PAUSED);
      e_load  = (m == M_LOAD);
      e_lval  = e_load ? m_start : '0;
      acc     = cmd_valid && e_ready;
      tick    = (m == M_RUN) && (m_phase == m_ps) && !acc;
      e_en    = tick && (m_cnt != m_lim);

      checks++; if (cmd_ready !== e_ready) begin errors++; $display("FAIL rnd_ready @%0d: got %b expected %b", cyc, cmd_ready, e_ready); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, busy, e_busy); end
      checks++; if (cnt_load !== e_load || cnt_load_val !== e_lval) begin errors++; $display("FAIL rnd_load @%0d: got %b/%0d expected %b/%0d", cyc, cnt_load, cnt_load_val, e_load, e_lval); end
      checks++; if (cnt_en !== e_en) begin errors++; $display("FAIL rnd_en @%0d: got %b expected %b", cyc, cnt_en, e_en); end
      checks++; if (done !== m_done_p) begin errors++; $display("FAIL rnd_done @%0d: got %b expected %b", cyc, done, m_done_p); end
      checks++; if (err !== m_err_p) begin errors++; $display("FAIL rnd_err @%0d: got %b expected %b", cyc, err, m_err_p); end
      checks++; if (cnt_q !== m_cnt) begin errors++; $display("FAIL rnd_count @%0d: got %0d expected %0d", cyc, cnt_q, m_cnt); end
      if (e_en || e_load) begin
        checks++; if (cnt_up !== m_up) begin errors++; $display("FAIL rnd_dir @%0d: got %b expected %b", cyc, cnt_up, m_up); end
      end

      // Advance the reference to the next cycle.
      m_done_p = tick && (m_cnt == m_lim);
      m_err_p  = 1'b0;
      if (e_load) m_cnt = m_start;
      else if (e_en) m_cnt = m_up ? m_cnt + 1'b1 : m_cnt - 1'b1;
      if (m == M_RUN && !acc) m_phase = (m_phase == m_ps) ? 0 : m_phase + 1;
      case (m)
        M_LOAD: begin m = M_RUN; m_phase = 0; end
        M_RUN: begin
          if (acc) begin
            if (cmd_op == C_PAUSE) m = M_PAUSED;
            else if (cmd_op == C_ABORT) m = M_IDLE;
            else m_err_p = 1'b1;
          end else if (m_done_p) m = M_DONE;
        end
        M_PAUSED: begin
          if (acc) begin
            if (cmd_op == C_RESUME) m = M_RUN;
            else if (cmd_op == C_ABORT) m = M_IDLE;
            else m_err_p = 1'b1;
          end
        end
        default: begin
          if (acc) begin
            if (cmd_op == C_SET_LIMIT) begin m_lim = cmd_data; m = M_IDLE; end
            else if (cmd_op == C_SET_PS) begin m_ps = int'(cmd_data) % 16; m = M_IDLE; end
            else if (cmd_op == C_START_UP || cmd_op == C_START_DN) begin
              m_up = (cmd_op == C_START_UP); m_start = cmd_data; m = M_LOAD;
            end else m_err_p = 1'b1;
          end
        end
      endcase

      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    clr();
    acc_cyc = 0;
    test_reset();
    test_basic_up();
    test_prescale_down();
    test_wrap();
    test_equal_start();
    test_pause_abort();
    test_err_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
